labmininios_led_out: RTL
========================

// Module: labmininios_led_out
// PURPOSE
//  Avalon-MM slave output PIO that drives board LEDs from Nios II software.
//  It is the write-side counterpart of the switch input PIO and shares its
//  bus timing: word-addressed registers and registered readdata.
//  Provides a data register, atomic set/clear aliases and an optional
//  per-bit hardware blink engine, so software need not poll timers.
// PARAMETERS
//  WIDTH         10          number of output bits / LEDs (1..32)
//  RESET_VALUE   0           DATA value loaded at reset (WIDTH bits)
//  PERIOD_RESET  25000000    BLINK_PERIOD reset value (0.5 s at 50 MHz)
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      async active-low reset
//  address    in   3      word address of the register
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe; qualified by chipselect
//  writedata  in   32     write data; bits above WIDTH ignored
//  readdata   out  32     registered read data
//  out_port   out  WIDTH  LED drive; registered
// BEHAVIOUR
//  One clock domain. reset_n is asynchronous assert, synchronous release.
//  Reset: DATA=RESET_VALUE, MASK=0, PERIOD=PERIOD_RESET, cnt=PERIOD_RESET,
//   phase=0, readdata=0, out_port=RESET_VALUE.
//  Write = chipselect & ~write_n, committed on that posedge. No wait states.
//  Register map (word address):
//   0 DATA    RW  out value
//   1 MASK    RW  bits that blink
//   2 PERIOD  RW  32-bit half-period in clocks; 0 = blink off
//   3 STATUS  RO  bit0=phase; other bits 0
//   4 OUTSET  WO  DATA <= DATA | wd; reads 0
//   5 OUTCLR  WO  DATA <= DATA & ~wd; reads 0
//   6,7       reserved: writes ignored, reads 0
//  Read: readdata <= zero-extended mux(address) on every clock, regardless of
//   chipselect; value is valid 1 cycle after address is presented. A read in
//   the same cycle as a write to the same register returns the old value.
//  Blink engine (2 states: PH0/PH1, held in phase):
//   PERIOD != 0: cnt decrements each clock. At cnt==0, phase toggles and
//    cnt reloads to PERIOD-1, so each phase lasts exactly PERIOD clocks.
//   PERIOD == 0: cnt and phase are held at 0; blinking is stopped.
//   Any PERIOD write sets cnt=new-1 (0 if new==0) and phase=0 on that edge.
//    This takes priority over a terminal count in the same cycle.
//  out_port <= DATA_next ^ (MASK_next & {WIDTH{phase_next}}).
//   out_port changes on the same edge that commits a write or a phase toggle.
//  MASK write does not restart the timer; newly masked bits follow the
//   current phase immediately.
//  Reset mid-blink: all state returns to reset values asynchronously.
// CONFIGURATION
//  LABMININIOS_LED_BLINK_EN defined: blink engine, MASK, PERIOD and STATUS
//   are implemented as above.
//  Not defined: no counter or phase logic. Addresses 1-3 read 0 and ignore
//   writes. out_port <= DATA_next.
// TESTING
//  Reset, then read addr 0 -> readdata=0x000 one cycle later, out_port=0.
//  Write DATA=0x3FF with wd upper bits=0xFFFFF -> out_port=0x3FF;
//   read addr 0 returns 0x000003FF.
//  DATA=0x0F0, OUTSET 0x003, OUTCLR 0x010 -> out_port 0x0F3 then 0x0E3;
//   read addr 4 returns 0.
//  PERIOD=4, MASK=0x001, DATA=0 -> out_port[0] toggles every 4 clocks;
//   STATUS bit0 tracks the phase.
//  Mid-blink PERIOD=0 -> phase=0 on the next edge; out_port=DATA and stays.
//  Blink active, assert reset_n low between clocks -> out_port=RESET_VALUE
//   immediately, PERIOD reads 25000000.

Source files
------------

// File: rtl/labmininios_led_out.sv
// labmininios_led_out
//   Avalon-MM slave output PIO driving board LEDs from Nios II software.
//   Word-addressed registers, no wait states, registered readdata.
//   Provides a DATA register, atomic OUTSET/OUTCLR aliases and, when the
//   macro LABMININIOS_LED_BLINK_EN is defined, a per-bit hardware blink
//   engine (MASK, PERIOD, STATUS registers).
//
// Register map (word address):
//   0 DATA    RW   1 MASK RW   2 PERIOD RW   3 STATUS RO (bit0 = phase)
//   4 OUTSET  WO   5 OUTCLR WO   6,7 reserved (read 0, writes ignored)
//   Without LABMININIOS_LED_BLINK_EN, addresses 1-3 read 0 and ignore writes.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset (assert async, release sync)
//   address     register word address
//   chipselect  slave select, qualifies write_n
//   write_n     active-low write strobe
//   writedata   write data; bits above WIDTH ignored (except PERIOD)
//   readdata    registered, zero-extended read data (one cycle latency)
//   out_port    registered LED drive
module labmininios_led_out #(
  parameter int unsigned      WIDTH        = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [31:0]      PERIOD_RESET = 32'd25000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_MASK   = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_OUTSET = 3'd4;
  localparam logic [2:0] A_OUTCLR = 3'd5;

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_next;
  logic [WIDTH-1:0] w_out_next;
  logic [31:0]      w_rd;
  logic             w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_wd     = writedata[WIDTH-1:0];
  assign w_unused = &{1'b0, writedata};

  always_comb begin
    w_data_next = r_data;
    if (w_wr) begin
      case (address)
        A_DATA:   w_data_next = w_wd;
        A_OUTSET: w_data_next = r_data | w_wd;
        A_OUTCLR: w_data_next = r_data & ~w_wd;
        default:  ;
      endcase
    end
  end

`ifdef LABMININIOS_LED_BLINK_EN
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] w_mask_next;
  logic [31:0]      r_period;
  logic [31:0]      w_period_next;
  logic [31:0]      r_cnt;
  logic [31:0]      w_cnt_next;
  logic             r_phase;
  logic             w_phase_next;

  // Blink engine: a PERIOD write restarts the timer in PH0 and wins over a
  // terminal count on the same edge. Reloading with PERIOD-1 at cnt==0 makes
  // each phase last exactly PERIOD clocks.
  always_comb begin
    w_mask_next   = r_mask;
    w_period_next = r_period;
    w_cnt_next    = r_cnt;
    w_phase_next  = r_phase;
    if (w_wr && address == A_MASK) begin
      w_mask_next = w_wd;
    end
    if (w_wr && address == A_PERIOD) begin
      w_period_next = writedata;
      w_cnt_next    = (writedata == 32'd0) ? 32'd0 : writedata - 32'd1;
      w_phase_next  = 1'b0;
    end else if (r_period == 32'd0) begin
      w_cnt_next   = 32'd0;
      w_phase_next = 1'b0;
    end else if (r_cnt == 32'd0) begin
      w_cnt_next   = r_period - 32'd1;
      w_phase_next = ~r_phase;
    end else begin
      w_cnt_next = r_cnt - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask   <= '0;
      r_period <= PERIOD_RESET;
      r_cnt    <= PERIOD_RESET;
      r_phase  <= 1'b0;
    end else begin
      r_mask   <= w_mask_next;
      r_period <= w_period_next;
      r_cnt    <= w_cnt_next;
      r_phase  <= w_phase_next;
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      A_DATA:   w_rd[WIDTH-1:0] = r_data;
      A_MASK:   w_rd[WIDTH-1:0] = r_mask;
      A_PERIOD: w_rd            = r_period;
      A_STATUS: w_rd[0]         = r_phase;
      default:  ;
    endcase
  end

  // Uses next-state values so out_port moves on the committing edge.
  assign w_out_next = w_data_next ^ (w_mask_next & {WIDTH{w_phase_next}});
`else
  always_comb begin
    w_rd = '0;
    if (address == A_DATA) begin
      w_rd[WIDTH-1:0] = r_data;
    end
  end

  assign w_out_next = w_data_next;
`endif

  // Readdata samples current registers, so a same-cycle write reads old data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= RESET_VALUE;
      readdata <= '0;
      out_port <= RESET_VALUE;
    end else begin
      r_data   <= w_data_next;
      readdata <= w_rd;
      out_port <= w_out_next;
    end
  end

endmodule
